// File: rtl/alu_issue_ctrl.sv
// Issue/response sequencer in front of the integer ALU: decodes one RV64I OP/OP-IMM/BRANCH
// request, drives registered ALU operands, then returns result, branch decision and illegal flag.
module alu_issue_ctrl #(
    parameter int WORDSIZE = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [6:0]          req_opcode,
    input  logic [2:0]          req_funct3,
    input  logic [6:0]          req_funct7,
    input  logic [WORDSIZE-1:0] req_rs1,
    input  logic [WORDSIZE-1:0] req_rs2,
    input  logic [WORDSIZE-1:0] req_imm,
    output logic [WORDSIZE-1:0] alu_input_a,
    output logic [WORDSIZE-1:0] alu_input_b,
    output logic [5:0]          alu_operation,
    input  logic [WORDSIZE-1:0] alu_result,
    input  logic                alu_flag_equal,
    input  logic                alu_flag_not_equal,
    input  logic                alu_flag_less,
    input  logic                alu_flag_u_less,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WORDSIZE-1:0] rsp_result,
    output logic                rsp_branch_taken,
    output logic                rsp_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [5:0] ALU_ADD = 6'b00_0000;
    localparam logic [5:0] ALU_SUB = 6'b00_0001;
    localparam logic [5:0] ALU_XOR = 6'b10_0011;
    localparam logic [5:0] ALU_OR  = 6'b10_0001;
    localparam logic [5:0] ALU_AND = 6'b10_0000;
    localparam logic [5:0] ALU_SLL = 6'b11_0011;
    localparam logic [5:0] ALU_SRL = 6'b11_0010;
    localparam logic [5:0] ALU_SRA = 6'b11_0000;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    typedef enum logic [2:0] {CLS_ALU, CLS_SLT, CLS_SLTU, CLS_BR, CLS_ILL} cls_t;

    state_t                state_q, state_d;
    cls_t                  cls_q, cls_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [5:0]            op_q, op_d;
    logic [WORDSIZE-1:0]   a_q, a_d;
    logic [WORDSIZE-1:0]   b_q, b_d;
    logic [WORDSIZE-1:0]   result_q, result_d;
    logic                  taken_q, taken_d;
    logic                  illegal_q, illegal_d;

    cls_t                  dec_cls;
    logic [5:0]            dec_op;
    logic [WORDSIZE-1:0]   dec_a;
    logic [WORDSIZE-1:0]   dec_b;
    logic                  is_op;
    logic [WORDSIZE-1:0]   src_b;

    // Only funct7[5] selects behaviour; the remaining bits are deliberately don't-care.
    logic unused_funct7;
    assign unused_funct7 = ^{req_funct7[6], req_funct7[4:0]};

    function automatic logic [WORDSIZE-1:0] shamt_of(input logic [WORDSIZE-1:0] v);
        return {{(WORDSIZE-6){1'b0}}, v[5:0]};
    endfunction

    function automatic logic branch_cond(input logic [2:0] f3, input logic eq, input logic ne,
                                         input logic lt, input logic ult);
        logic c;
        case (f3)
            3'b000:  c = eq;
            3'b001:  c = ne;
            3'b100:  c = lt;
            3'b101:  c = !lt;
            3'b110:  c = ult;
            3'b111:  c = !ult;
            default: c = 1'b0;
        endcase
        return c;
    endfunction

    always_comb begin
        dec_cls = CLS_ILL;
        dec_op  = ALU_ADD;
        dec_a   = '0;
        dec_b   = '0;
        is_op   = (req_opcode == OPC_OP);
        src_b   = is_op ? req_rs2 : req_imm;
        if (is_op || req_opcode == OPC_OP_IMM) begin
            dec_cls = CLS_ALU;
            dec_a   = req_rs1;
            dec_b   = src_b;
            case (req_funct3)
                3'b000: dec_op = (is_op && req_funct7[5]) ? ALU_SUB : ALU_ADD;
                3'b100: dec_op = ALU_XOR;
                3'b110: dec_op = ALU_OR;
                3'b111: dec_op = ALU_AND;
                3'b001: begin
                    dec_op = ALU_SLL;
                    dec_b  = shamt_of(src_b);
                end
                3'b101: begin
                    dec_op = req_funct7[5] ? ALU_SRA : ALU_SRL;
                    dec_b  = shamt_of(src_b);
                end
                3'b010: begin
                    dec_op  = ALU_SUB;
                    dec_cls = CLS_SLT;
                end
                default: begin
                    dec_op  = ALU_SUB;
                    dec_cls = CLS_SLTU;
                end
            endcase
        end else if (req_opcode == OPC_BRANCH && req_funct3[2:1] != 2'b01) begin
            dec_cls = CLS_BR;
            dec_op  = ALU_SUB;
            dec_a   = req_rs1;
            dec_b   = req_rs2;
        end
    end

    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        funct3_d  = funct3_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        taken_d   = taken_q;
        illegal_d = illegal_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d  = EXEC;
                    cls_d    = dec_cls;
                    funct3_d = req_funct3;
                    op_d     = dec_op;
                    a_d      = dec_a;
                    b_d      = dec_b;
                end
            end
            EXEC: begin
                state_d   = RESP;
                taken_d   = 1'b0;
                illegal_d = 1'b0;
                case (cls_q)
                    CLS_ALU:  result_d = alu_result;
                    CLS_SLT:  result_d = {{(WORDSIZE-1){1'b0}}, alu_flag_less};
                    CLS_SLTU: result_d = {{(WORDSIZE-1){1'b0}}, alu_flag_u_less};
                    CLS_BR: begin
                        result_d = '0;
                        taken_d  = branch_cond(funct3_q, alu_flag_equal, alu_flag_not_equal,
                                               alu_flag_less, alu_flag_u_less);
                    end
                    default: begin
                        result_d  = '0;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cls_q     <= CLS_ALU;
            funct3_q  <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            funct3_q  <= funct3_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            result_q  <= result_d;
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
        end
    end

    assign req_ready        = (state_q == IDLE);
    assign rsp_valid        = (state_q == RESP);
    assign alu_operation    = op_q;
    assign alu_input_a      = a_q;
    assign alu_input_b      = b_q;
    assign rsp_result       = result_q;
    assign rsp_branch_taken = taken_q;
    assign rsp_illegal      = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized and directed bench for alu_issue_ctrl with an ALU stand-in and an
// instruction-level reference model compared every cycle.
module tb_alu_issue_ctrl;

    localparam int W = 64;
    localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, BR = 7'b1100011;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [6:0]    req_opcode = '0;
    logic [2:0]    req_funct3 = '0;
    logic [6:0]    req_funct7 = '0;
    logic [W-1:0]  req_rs1 = '0, req_rs2 = '0, req_imm = '0;
    logic [W-1:0]  alu_input_a, alu_input_b, alu_result;
    logic [5:0]    alu_operation;
    logic          alu_flag_equal, alu_flag_not_equal, alu_flag_less, alu_flag_u_less;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [W-1:0]  rsp_result;
    logic          rsp_branch_taken, rsp_illegal;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ready_mode = 0;

    logic          lit_en = 1'b0;
    logic [W-1:0]  lit_res = '0, lit_b = '0;
    logic          lit_tk = 1'b0, lit_il = 1'b0;
    logic [5:0]    lit_op = '0;

    typedef struct {
        logic [5:0]   op;
        logic [W-1:0] a, b, res;
        logic         tk, il;
        int           acc;
        logic         lit;
        logic [W-1:0] lres, lb;
        logic         ltk, lil;
        logic [5:0]   lop;
    } exp_t;

    exp_t q[$];
    exp_t last_e, new_e;
    logic last_v = 1'b0;
    logic front_seen = 1'b0;
    logic in_rst = 1'b0;

    alu_issue_ctrl #(.WORDSIZE(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_funct3(req_funct3), .req_funct7(req_funct7),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .alu_input_a(alu_input_a), .alu_input_b(alu_input_b), .alu_operation(alu_operation),
        .alu_result(alu_result),
        .alu_flag_equal(alu_flag_equal), .alu_flag_not_equal(alu_flag_not_equal),
        .alu_flag_less(alu_flag_less), .alu_flag_u_less(alu_flag_u_less),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_branch_taken(rsp_branch_taken), .rsp_illegal(rsp_illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'($urandom_range(0, 1));
            default: rsp_ready = 1'b0;
        endcase
    end

    // Stand-in for the attached alu and its flagger.
    always_comb begin
        case (alu_operation)
            6'h00:   alu_result = alu_input_a + alu_input_b;
            6'h01:   alu_result = alu_input_a - alu_input_b;
            6'h23:   alu_result = alu_input_a ^ alu_input_b;
            6'h21:   alu_result = alu_input_a | alu_input_b;
            6'h20:   alu_result = alu_input_a & alu_input_b;
            6'h33:   alu_result = alu_input_a << alu_input_b[5:0];
            6'h32:   alu_result = alu_input_a >> alu_input_b[5:0];
            6'h30:   alu_result = W'($signed(alu_input_a) >>> alu_input_b[5:0]);
            default: alu_result = '0;
        endcase
        alu_flag_equal     = (alu_input_a == alu_input_b);
        alu_flag_not_equal = (alu_input_a != alu_input_b);
        alu_flag_less      = ($signed(alu_input_a) < $signed(alu_input_b));
        alu_flag_u_less    = (alu_input_a < alu_input_b);
    end

    function automatic exp_t ref_model(input logic [6:0] opc, input logic [2:0] f3,
                                       input logic [6:0] f7, input logic [W-1:0] rs1,
                                       input logic [W-1:0] rs2, input logic [W-1:0] imm);
        exp_t e;
        logic [W-1:0] bv;
        e = '{default: '0};
        if (opc == OP || opc == OPI) begin
            bv  = (opc == OP) ? rs2 : imm;
            e.a = rs1;
            e.b = bv;
            case (f3)
                3'd0: if (opc == OP && f7[5]) begin e.op = 6'h01; e.res = rs1 - bv; end
                      else begin e.op = 6'h00; e.res = rs1 + bv; end
                3'd4: begin e.op = 6'h23; e.res = rs1 ^ bv; end
                3'd6: begin e.op = 6'h21; e.res = rs1 | bv; end
                3'd7: begin e.op = 6'h20; e.res = rs1 & bv; end
                3'd1: begin e.op = 6'h33; e.b = W'(bv[5:0]); e.res = rs1 << bv[5:0]; end
                3'd5: begin
                    e.b = W'(bv[5:0]);
                    if (f7[5]) begin e.op = 6'h30; e.res = W'($signed(rs1) >>> bv[5:0]); end
                    else begin e.op = 6'h32; e.res = rs1 >> bv[5:0]; end
                end
                3'd2: begin e.op = 6'h01; e.res = W'($signed(rs1) < $signed(bv)); end
                default: begin e.op = 6'h01; e.res = W'(rs1 < bv); end
            endcase
        end else if (opc == BR && f3 != 3'd2 && f3 != 3'd3) begin
            e.op = 6'h01;
            e.a  = rs1;
            e.b  = rs2;
            case (f3)
                3'd0:    e.tk = (rs1 == rs2);
                3'd1:    e.tk = (rs1 != rs2);
                3'd4:    e.tk = ($signed(rs1) < $signed(rs2));
                3'd5:    e.tk = !($signed(rs1) < $signed(rs2));
                3'd6:    e.tk = (rs1 < rs2);
                default: e.tk = !(rs1 < rs2);
            endcase
        end else begin
            e.il = 1'b1;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at t=%0t", name, got, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                if (!in_rst) begin
                    in_rst = 1'b1;
                    #1;
                    chk("rst_rsp_valid", W'(rsp_valid), 0);
                    chk("rst_req_ready", W'(req_ready), 1);
                    chk("rst_alu_op", W'(alu_operation), 0);
                    chk("rst_alu_a", alu_input_a, 0);
                    chk("rst_alu_b", alu_input_b, 0);
                    chk("rst_rsp_result", rsp_result, 0);
                    chk("rst_rsp_flags", W'({rsp_branch_taken, rsp_illegal}), 0);
                    q.delete();
                    last_v = 1'b0;
                    front_seen = 1'b0;
                end
            end else begin
                in_rst = 1'b0;
                chk("req_ready", W'(req_ready), W'(q.size() == 0));
                if (last_v) begin
                    chk("alu_operation", W'(alu_operation), W'(last_e.op));
                    chk("alu_input_a", alu_input_a, last_e.a);
                    chk("alu_input_b", alu_input_b, last_e.b);
                end
                if (rsp_valid) begin
                    if (q.size() == 0) begin
                        chk("spurious_rsp_valid", W'(rsp_valid), 0);
                    end else begin
                        if (!front_seen) begin
                            chk("latency_cycle", W'(cyc), W'(q[0].acc + 1));
                            front_seen = 1'b1;
                        end
                        chk("rsp_result", rsp_result, q[0].res);
                        chk("rsp_branch_taken", W'(rsp_branch_taken), W'(q[0].tk));
                        chk("rsp_illegal", W'(rsp_illegal), W'(q[0].il));
                        if (rsp_ready) begin
                            if (q[0].lit) begin
                                chk("pin_result", rsp_result, q[0].lres);
                                chk("pin_taken", W'(rsp_branch_taken), W'(q[0].ltk));
                                chk("pin_illegal", W'(rsp_illegal), W'(q[0].lil));
                                chk("pin_alu_op", W'(alu_operation), W'(q[0].lop));
                                chk("pin_alu_b", alu_input_b, q[0].lb);
                            end
                            void'(q.pop_front());
                            front_seen = 1'b0;
                        end
                    end
                end
                if (req_valid && req_ready) begin
                    new_e = ref_model(req_opcode, req_funct3, req_funct7, req_rs1, req_rs2, req_imm);
                    new_e.acc  = cyc + 1;
                    new_e.lit  = lit_en;
                    new_e.lres = lit_res;
                    new_e.ltk  = lit_tk;
                    new_e.lil  = lit_il;
                    new_e.lop  = lit_op;
                    new_e.lb   = lit_b;
                    q.push_back(new_e);
                    last_e = new_e;
                    last_v = 1'b1;
                end
            end
        end
    end

    task automatic drive_req(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                             input logic [W-1:0] rs1, input logic [W-1:0] rs2,
                             input logic [W-1:0] imm);
        @(posedge clk);
        #1;
        req_opcode = opc; req_funct3 = f3; req_funct7 = f7;
        req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
        req_valid = 1'b1;
    endtask

    task automatic wait_accept();
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            $display("FAIL accept_timeout req_ready stuck low");
            $fatal(1, "timeout");
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lit_en = 1'b0;
    endtask

    task automatic send(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [W-1:0] rs1, input logic [W-1:0] rs2, input logic [W-1:0] imm);
        drive_req(opc, f3, f7, rs1, rs2, imm);
        wait_accept();
    endtask

    task automatic pin(input logic [W-1:0] res, input logic tk, input logic il,
                       input logic [5:0] op, input logic [W-1:0] b);
        lit_en = 1'b1; lit_res = res; lit_tk = tk; lit_il = il; lit_op = op; lit_b = b;
    endtask

    task automatic wait_rsp_valid();
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rsp_valid) begin ok = 1; break; end
        end
        if (!ok) begin
            $display("FAIL rsp_timeout rsp_valid never rose");
            $fatal(1, "timeout");
        end
    endtask

    task automatic drain();
        bit ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !rsp_valid) begin ok = 1; break; end
        end
        if (!ok) begin
            $display("FAIL drain_timeout outstanding=%0d", q.size());
            $fatal(1, "timeout");
        end
    endtask

    function automatic logic [W-1:0] rnd_word();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return W'($urandom_range(0, 70));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        logic [6:0]   ropc;
        logic [W-1:0] r1, r2;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        ready_mode = 0;
        pin(64'd12, 0, 0, 6'h00, 64'd7);
        send(OP, 3'd0, 7'h00, 64'd5, 64'd7, 64'd0);
        drain();
        pin(64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 6'h01, 64'd7);
        send(OP, 3'd0, 7'h20, 64'd5, 64'd7, 64'd0);
        drain();
        pin(64'hF800_0000_0000_0000, 0, 0, 6'h30, 64'd4);
        send(OPI, 3'd5, 7'h20, 64'h8000_0000_0000_0000, 64'd0, 64'h44);
        drain();
        pin(64'd1, 0, 0, 6'h01, 64'd1);
        send(OP, 3'd2, 7'h00, '1, 64'd1, 64'd0);
        drain();
        pin(64'd0, 0, 0, 6'h01, 64'd1);
        send(OP, 3'd3, 7'h00, '1, 64'd1, 64'd0);
        drain();
        pin(64'd0, 1, 0, 6'h01, 64'd3);
        send(BR, 3'd4, 7'h00, -64'sd2, 64'd3, 64'd0);
        drain();
        pin(64'd0, 1, 0, 6'h01, 64'd3);
        send(BR, 3'd7, 7'h00, -64'sd2, 64'd3, 64'd0);
        drain();
        pin(64'd0, 1, 0, 6'h01, 64'd4);
        send(BR, 3'd0, 7'h00, 64'd4, 64'd4, 64'd0);
        drain();
        pin(64'd0, 0, 0, 6'h01, 64'd4);
        send(BR, 3'd1, 7'h00, 64'd4, 64'd4, 64'd0);
        drain();
        pin(64'd0, 0, 1, 6'h00, 64'd0);
        send(BR, 3'd2, 7'h00, 64'd4, 64'd4, 64'd0);
        drain();

        // Backpressure: response stalls while a second request waits.
        ready_mode = 2;
        send(OP, 3'd0, 7'h00, 64'd5, 64'd7, 64'd0);
        wait_rsp_valid();
        pin(64'd0, 0, 1, 6'h00, 64'd0);
        drive_req(7'h7F, 3'd0, 7'h00, 64'd9, 64'd9, 64'd9);
        repeat (10) @(negedge clk);
        ready_mode = 0;
        wait_accept();
        drain();

        // Asynchronous reset while a response is being held.
        ready_mode = 2;
        send(OP, 3'd0, 7'h20, 64'd100, 64'd1, 64'd0);
        wait_rsp_valid();
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        ready_mode = 0;
        repeat (6) @(negedge clk);

        ready_mode = 1;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: ropc = OP;
                4, 5, 6:    ropc = OPI;
                7, 8:       ropc = BR;
                default:    ropc = 7'($urandom_range(0, 127));
            endcase
            r1 = rnd_word();
            r2 = ($urandom_range(0, 3) == 0) ? r1 : rnd_word();
            send(ropc, 3'($urandom_range(0, 7)),
                 {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31))},
                 r1, r2, rnd_word());
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
